mem_burst_responder: RTL and testbench
======================================

# mem_burst_responder

Multi-cycle data-memory responder serving the pipeline's memory-stage requests and future cache line fills. It accepts single-word reads and writes plus aligned burst reads over a valid/ready request channel. Read data returns on a fixed-latency response channel, one word per cycle. It replaces the single-cycle data memory as the far end of the CPU's memory interface.

## Interface
- `ADDR_W`, 16: byte address width.
- `DATA_W`, 16: word width.
- `DEPTH`, 32768: number of words in the array.
- `LATENCY`, 4: cycles from request acceptance to response; must be ≥1.
- `BURST_LEN`, 8: words per burst; must be a power of two.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high. Clears control state only; array contents are retained.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request this cycle.
- `req_wr`  in  1  1 = single-word write, 0 = read.
- `req_burst`  in  1  1 = burst read. Ignored when `req_wr`=1.
- `req_addr`  in  ADDR_W  byte address; bit 0 is ignored.
- `req_wdata`  in  DATA_W  write data.
- `rsp_valid`  out  1  response word valid.
- `rsp_data`  out  DATA_W  read data.
- `rsp_last`  out  1  final word of a response; 1 for single reads.
- `busy`  out  1  burst issue in progress or any response still in flight.

## Operation
- A request is accepted in a cycle where `req_valid` & `req_ready` are both high.
- FSM states:
  - IDLE: `req_ready`=1 (0 while `rst` is high).
  - BURST: `req_ready`=0.
- Single write: the array is updated at the accepting edge; no response is produced.
- Single read: the word at `req_addr[ADDR_W-1:1]` enters the read pipeline at the accepting edge with last=1.
- Burst read, base = `req_addr` with the low log2(BURST_LEN)+1 bits cleared:
  - The word at base enters the pipeline at acceptance, and the FSM moves to BURST with counter=1.
  - Each BURST cycle issues word base+2·counter and increments the counter.
  - The word with counter=BURST_LEN-1 is issued with last=1, and the FSM returns to IDLE.
  - Words are issued in ascending order with no wrap within the burst.
- Array read is sampled at issue. A write accepted at edge k is therefore visible to a read accepted at edge k+1 or later.
- Word index arithmetic is modulo DEPTH; higher address bits are ignored.
- Back-to-back single requests are accepted every cycle in IDLE. Responses are never dropped or reordered.
- There is no response backpressure; the consumer must always accept `rsp_valid`.
- Reset mid-operation:
  - FSM goes to IDLE and the counter is cleared.
  - All pipeline valid bits are cleared, so in-flight responses are discarded.
  - Array contents are untouched.

## Timing
- Reset values: `rsp_valid`=0, `rsp_data`=0, `rsp_last`=0, `busy`=0, `req_ready`=0 during `rst`. `req_ready`=1 in the first cycle after `rst` deasserts.
- Request accepted at edge k: `rsp_valid` is high in the cycle following edge k+LATENCY-1, i.e. LATENCY edges after acceptance inclusive of the accepting edge.
- A burst accepted at edge k delivers words on LATENCY … LATENCY+BURST_LEN-1 consecutive cycles, with `rsp_last` on the final one.
- `req_ready` is low for exactly BURST_LEN-1 cycles after burst acceptance.
- `rsp_data` holds its last value when `rsp_valid`=0. Only `rsp_valid` and `rsp_last` are cleared.
- `busy` is combinational: (state≠IDLE) | OR of the pipeline valid bits.

## Structure
- Shared package `mem_pkg`:
  - default ADDR_W, DATA_W, LATENCY, BURST_LEN;
  - the FSM state enum {IDLE, BURST};
  - a response-beat struct {valid, last, data}.
- One sub-module, `mem_read_pipe`: a LATENCY-deep shift register of response beats with synchronous clear. Stage 0 is loaded from the array read.
- The array is inferred as a synchronous-write register array; no file preload.

## Test plan
- Reset, then write 0x1234 to 0x0010 and read 0x0010 on the next cycle → `rsp_valid` 4 cycles after read acceptance, `rsp_data`=0x1234, `rsp_last`=1.
- Write 0xA000+i to 0x0040+2i for i=0..7, then burst read 0x0046 → 8 consecutive beats 0xA000…0xA007 starting at latency 4, `rsp_last` on beat 8, `req_ready` low for 7 cycles.
- Single reads of 0x0040, 0x0042, 0x0044 on 3 consecutive cycles → 3 consecutive beats in order, each with `rsp_last`=1, `busy` high until the last beat.
- Write 0xBEEF to 0x0021 → a read of 0x0020 returns 0xBEEF (bit 0 ignored).
- Assert `rst` for 1 cycle, 2 cycles into a burst → no `rsp_valid` afterwards, `busy`=0 and `req_ready`=1 after reset. A subsequent read of 0x0040 returns 0xA000 (contents retained).
- Hold `req_valid` during BURST with a write request → no write occurs until `req_ready` returns; the write is accepted on the first IDLE cycle.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and default parameters for the burst memory responder.
package mem_pkg;

  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_DEPTH     = 32768;
  localparam int DEF_LATENCY   = 4;
  localparam int DEF_BURST_LEN = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // One response beat travelling down the read pipeline.
  typedef struct packed {
    logic                  valid;
    logic                  last;
    logic [DEF_DATA_W-1:0] data;
  } beat_t;

endpackage

// File: rtl/mem_read_pipe.sv
// Fixed-latency shift register of response beats. Stage 0 takes the array
// read; the last stage drives the response port. Data of a stage only moves
// on a valid beat so the output word holds while the channel is idle.
module mem_read_pipe
  import mem_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic  clk,
  input  logic  clr,
  input  beat_t in_beat,
  output beat_t out_beat,
  output logic  any_valid
);

  beat_t stage_q [LATENCY];
  beat_t stage_d [LATENCY];

  // Next-stage values: valid/last always shift, data only with a valid beat.
  always_comb begin
    stage_d[0].valid = in_beat.valid;
    stage_d[0].last  = in_beat.last;
    stage_d[0].data  = in_beat.valid ? in_beat.data : stage_q[0].data;
    for (int i = 1; i < LATENCY; i++) begin
      stage_d[i].valid = stage_q[i-1].valid;
      stage_d[i].last  = stage_q[i-1].last;
      stage_d[i].data  = stage_q[i-1].valid ? stage_q[i-1].data : stage_q[i].data;
    end
  end

  // Pipeline registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      stage_q <= '{default: '0};
    end else begin
      stage_q <= stage_d;
    end
  end

  // Any beat still in flight.
  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < LATENCY; i++) begin
      any_valid = any_valid | stage_q[i].valid;
    end
  end

  assign out_beat = stage_q[LATENCY-1];

endmodule

// File: rtl/mem_burst_responder.sv
// Multi-cycle data memory: single reads/writes and aligned burst reads on a
// valid/ready request channel, fixed-latency read responses, one word/cycle.
// DEPTH is taken to be a power of two so word-index wrap is plain truncation.
module mem_burst_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int LATENCY   = DEF_LATENCY,
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic              req_burst,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              busy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic BURST_EN = (BURST_LEN > 1);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam idx_t BURST_MASK = idx_t'(BURST_LEN - 1);
  localparam cnt_t CNT_LAST   = cnt_t'(BURST_LEN - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];

  state_t state_q, state_d;
  cnt_t   cnt_q,   cnt_d;
  idx_t   base_q,  base_d;

  logic        accept;
  idx_t        req_idx;
  idx_t        issue_idx;
  logic        issue_valid;
  logic        issue_last;
  beat_t       in_beat;
  beat_t       out_beat;
  logic        pipe_busy;

  assign req_ready = ~rst & (state_q == IDLE);
  assign accept    = req_valid & req_ready;
  assign req_idx   = idx_t'(req_addr[ADDR_W-1:1]);

  // Issue selection and next-state for the burst sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    base_d      = base_q;
    issue_idx   = req_idx;
    issue_valid = 1'b0;
    issue_last  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept && !req_wr) begin
          issue_valid = 1'b1;
          if (req_burst && BURST_EN) begin
            issue_idx = req_idx & ~BURST_MASK;
            base_d    = req_idx & ~BURST_MASK;
            cnt_d     = cnt_t'(1);
            state_d   = BURST;
          end else begin
            issue_idx  = req_burst ? (req_idx & ~BURST_MASK) : req_idx;
            issue_last = 1'b1;
          end
        end
      end
      BURST: begin
        issue_valid = 1'b1;
        issue_idx   = base_q + idx_t'(cnt_q);
        cnt_d       = cnt_q + cnt_t'(1);
        if (cnt_q == CNT_LAST) begin
          issue_last = 1'b1;
          cnt_d      = '0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Burst sequencer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
    end
  end

  // Word array: written at the accepting edge, never cleared by reset.
  always_ff @(posedge clk) begin
    if (accept && req_wr) begin
      mem_q[req_idx] <= req_wdata;
    end
  end

  // Beat entering the pipeline this cycle, read from the array at issue.
  always_comb begin
    in_beat       = '0;
    in_beat.valid = issue_valid;
    in_beat.last  = issue_last;
    in_beat.data  = mem_q[issue_idx];
  end

  mem_read_pipe #(
    .LATENCY (LATENCY)
  ) u_read_pipe (
    .clk       (clk),
    .clr       (rst),
    .in_beat   (in_beat),
    .out_beat  (out_beat),
    .any_valid (pipe_busy)
  );

  assign rsp_valid = out_beat.valid;
  assign rsp_last  = out_beat.last;
  assign rsp_data  = out_beat.data;
  assign busy      = (state_q != IDLE) | pipe_busy;

endmodule

// File: tb/tb_mem_burst_responder.sv
// Scenario bench for mem_burst_responder with an expected-beat scoreboard.
module tb_mem_burst_responder;

  localparam int LAT   = 4;
  localparam int BL    = 8;
  localparam int DEPTH = 32768;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic        req_burst = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_last;
  logic        busy;

  typedef struct {
    logic [15:0] data;
    logic        last;
    int          due;
  } exp_t;

  exp_t        sb_q [$];
  logic [15:0] model [int];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  mem_burst_responder dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_burst (req_burst),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_last  (rsp_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor: pops the scoreboard on every delivered beat.
  always @(negedge clk) begin
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].due < cyc) begin
      e = sb_q.pop_front();
      n_vec++; n_err++;
      $display("FAIL missed_beat: due cycle %0d, data %h never delivered (now %0d)", e.due, e.data, cyc);
    end
    if (!rst && rsp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_rsp: got data %h last %b at cycle %0d, none expected", rsp_data, rsp_last, cyc);
      end else begin
        e = sb_q.pop_front();
        n_vec++;
        if (rsp_data !== e.data) begin
          n_err++;
          $display("FAIL rsp_data: got %h, expected %h (cycle %0d)", rsp_data, e.data, cyc);
        end
        n_vec++;
        if (rsp_last !== e.last) begin
          n_err++;
          $display("FAIL rsp_last: got %b, expected %b (cycle %0d)", rsp_last, e.last, cyc);
        end
        n_vec++;
        if (cyc != e.due) begin
          n_err++;
          $display("FAIL rsp_latency: beat at cycle %0d, expected cycle %0d", cyc, e.due);
        end
      end
    end
  end

  // Present one request, wait for acceptance, record expected beats.
  task automatic issue(input logic wr, input logic burst, input logic [15:0] addr,
                       input logic [15:0] wdata, output int waited);
    int idx, base;
    waited    = 0;
    req_valid = 1'b1;
    req_wr    = wr;
    req_burst = burst;
    req_addr  = addr;
    req_wdata = wdata;
    while (req_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (req_ready !== 1'b1) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: req_ready %b after %0d cycles, expected 1", req_ready, waited);
    end else begin
      idx = (int'(addr) >> 1) & (DEPTH - 1);
      if (wr) begin
        model[idx] = wdata;
      end else if (burst) begin
        base = idx & ~(BL - 1);
        for (int j = 0; j < BL; j++)
          sb_q.push_back('{model[(base + j) & (DEPTH - 1)], (j == BL - 1), cyc + LAT + j});
      end else begin
        sb_q.push_back('{model[idx], 1'b1, cyc + LAT});
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() > 0) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: %0d beats outstanding, expected 0", sb_q.size());
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_vec++;
    if ({rsp_valid, rsp_last, busy, req_ready} !== 4'b0000 || rsp_data !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_outputs: valid %b last %b busy %b ready %b data %h, expected all 0",
               rsp_valid, rsp_last, busy, req_ready, rsp_data);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ready_after_reset: got %b, expected 1", req_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_write_read();
    int w;
    issue(1'b1, 1'b0, 16'h0010, 16'h1234, w);
    issue(1'b0, 1'b0, 16'h0010, 16'h0000, w);
    drain();
  endtask

  task automatic test_burst();
    int w, lows;
    for (int i = 0; i < BL; i++)
      issue(1'b1, 1'b0, 16'h0040 + 16'(2 * i), 16'hA000 + 16'(i), w);
    issue(1'b0, 1'b1, 16'h0046, 16'h0000, w);
    lows = 0;
    while (req_ready !== 1'b1 && lows < 20) begin
      lows++;
      @(negedge clk);
    end
    n_vec++;
    if (lows != BL - 1) begin
      n_err++;
      $display("FAIL burst_ready_low: req_ready low %0d cycles, expected %0d", lows, BL - 1);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int w;
    issue(1'b0, 1'b0, 16'h0040, 16'h0000, w);
    issue(1'b0, 1'b0, 16'h0042, 16'h0000, w);
    issue(1'b0, 1'b0, 16'h0044, 16'h0000, w);
    for (int n = 0; n < 20; n++) begin
      #1;
      if (sb_q.size() == 0) break;
      n_vec++;
      if (busy !== 1'b1) begin
        n_err++;
        $display("FAIL busy_in_flight: got %b, expected 1", busy);
      end
      @(negedge clk);
    end
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL busy_last_beat: got %b, expected 1", busy);
    end
    @(negedge clk);
    #1;
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL busy_after_drain: got %b, expected 0", busy);
    end
    drain();
  endtask

  task automatic test_bit0_ignored();
    int w;
    issue(1'b1, 1'b0, 16'h0021, 16'hBEEF, w);
    issue(1'b0, 1'b0, 16'h0020, 16'h0000, w);
    drain();
  endtask

  task automatic test_write_held_in_burst();
    int w;
    issue(1'b0, 1'b1, 16'h0040, 16'h0000, w);
    issue(1'b1, 1'b0, 16'h0042, 16'h7777, w);
    n_vec++;
    if (w != BL - 1) begin
      n_err++;
      $display("FAIL held_write_wait: accepted after %0d cycles, expected %0d", w, BL - 1);
    end
    issue(1'b0, 1'b0, 16'h0042, 16'h0000, w);
    drain();
  endtask

  task automatic test_reset_mid_burst();
    int w, seen;
    issue(1'b0, 1'b1, 16'h0040, 16'h0000, w);
    @(negedge clk);
    rst = 1'b1;
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset_state: busy %b ready %b, expected 0 and 1", busy, req_ready);
    end
    seen = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) seen++;
    end
    n_vec++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL mid_reset_discard: %0d response beats after reset, expected 0", seen);
    end
    issue(1'b0, 1'b0, 16'h0040, 16'h0000, w);
    n_vec++;
    if (sb_q.size() != 1 || sb_q[0].data !== 16'hA000) begin
      n_err++;
      $display("FAIL retained_expect: scoreboard holds %0d beats, expected 1 beat of A000", sb_q.size());
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_burst();
    test_back_to_back();
    test_bit0_ignored();
    test_write_held_in_burst();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
